// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// the hard-wired zero register number and default timing parameters.
// No ports; imported by hazard_detect and pipeline_hazard_ctrl.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO          = 5'd0;
    localparam int          DEF_MC_LATENCY    = 4;
    localparam int          DEF_FLUSH_CYCLES  = 2;
    localparam int          CNT_W             = 4;
    localparam logic [15:0] STALL_MAX         = 16'hFFFF;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction reading the register a
// load in EX is about to write. Purely combinational.
// Ports: i_id_rs/i_id_rt (ID sources), i_ex_mem_read/i_ex_write_address (EX load), lu_hazard.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_write_address,
    output logic       lu_hazard
);

    // Writes to $0 are discarded, so a load targeting it never creates a dependency.
    assign lu_hazard = i_ex_mem_read
                    && (i_ex_write_address != REG_ZERO)
                    && ((i_ex_write_address == i_id_rs) || (i_ex_write_address == i_id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multicycle ALU holds and
// post-branch flushes, plus a saturating count of PC-stalled cycles.
// Ports: clk/rst, ID/EX hazard inputs, buffer enables/flushes, o_state, o_stall_count.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MC_LATENCY   = DEF_MC_LATENCY,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_write_address,
    input  logic        i_branch_taken,
    input  logic        i_id_multicycle,
    output logic        o_pc_write,
    output logic        o_if_id_write,
    output logic        o_id_ex_enable,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic [1:0]  o_state,
    output logic [15:0] o_stall_count
);

    // The cycle that enters MC_WAIT/FLUSH already counts as the first held or
    // flushed cycle, and the cnt=0 cycle counts as the last, hence the -2.
    localparam logic [CNT_W-1:0] MC_RELOAD = CNT_W'(MC_LATENCY - 2);
    localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_CYCLES - 2);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_ack_q, mc_ack_d;
    logic [15:0]      stall_q;
    logic             lu_hazard;

    hazard_detect u_hazard_detect (
        .i_id_rs            (i_id_rs),
        .i_id_rt            (i_id_rt),
        .i_ex_mem_read      (i_ex_mem_read),
        .i_ex_write_address (i_ex_write_address),
        .lu_hazard          (lu_hazard)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mc_ack_d       = mc_ack_q;
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_id_ex_enable = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;

        if (i_branch_taken) begin
            // A taken branch wins in every state and restarts the flush window,
            // abandoning any multicycle hold in progress.
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            mc_ack_d      = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FL_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // mc_ack only shields the single RUN cycle after a hold.
                    mc_ack_d = 1'b0;
                    if (lu_hazard) begin
                        o_pc_write    = 1'b0;
                        o_if_id_write = 1'b0;
                        o_id_ex_flush = 1'b1;
                    end else if (i_id_multicycle && !mc_ack_q) begin
                        o_pc_write     = 1'b0;
                        o_if_id_write  = 1'b0;
                        o_id_ex_enable = 1'b0;
                        if (MC_LATENCY > 1) begin
                            state_d = ST_MC_WAIT;
                            cnt_d   = MC_RELOAD;
                        end else begin
                            mc_ack_d = 1'b1;
                        end
                    end
                end
                ST_MC_WAIT: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_enable = 1'b0;
                    if (cnt_q == '0) begin
                        state_d  = ST_RUN;
                        mc_ack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    mc_ack_d      = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    mc_ack_d = 1'b0;
                end
            endcase
        end

        // Reset must present a free-running pipeline regardless of inputs.
        if (rst) begin
            o_pc_write     = 1'b1;
            o_if_id_write  = 1'b1;
            o_id_ex_enable = 1'b1;
            o_if_id_flush  = 1'b0;
            o_id_ex_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            mc_ack_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_ack_q <= mc_ack_d;
            if (!o_pc_write && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign o_state       = state_q;
    assign o_stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MCL = 4;
    localparam int FC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs, rt, wa;
    logic        mr, br, mc;
    logic        pc_write, if_id_write, id_ex_enable, if_id_flush, id_ex_flush;
    logic [1:0]  state;
    logic [15:0] stall_count;

    pipeline_hazard_ctrl #(.MC_LATENCY(MCL), .FLUSH_CYCLES(FC)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_id_rs            (rs),
        .i_id_rt            (rt),
        .i_ex_mem_read      (mr),
        .i_ex_write_address (wa),
        .i_branch_taken     (br),
        .i_id_multicycle    (mc),
        .o_pc_write         (pc_write),
        .o_if_id_write      (if_id_write),
        .o_id_ex_enable     (id_ex_enable),
        .o_if_id_flush      (if_id_flush),
        .o_id_ex_flush      (id_ex_flush),
        .o_state            (state),
        .o_stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model in terms of "cycles remaining" rather than state/counter.
    int mc_left, fl_left, stalls;
    bit ack;
    int n_mc_left, n_fl_left;
    bit n_ack;
    bit e_pc, e_ifid, e_idex, e_iff, e_idf;
    int e_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mc_left = 0; fl_left = 0; ack = 0; stalls = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = mr && (wa != 0) && ((wa == rs) || (wa == rt));
        e_pc = 1; e_ifid = 1; e_idex = 1; e_iff = 0; e_idf = 0;
        n_mc_left = mc_left; n_fl_left = fl_left; n_ack = ack;
        e_state = (fl_left > 0) ? 2 : (mc_left > 0) ? 1 : 0;
        if (rst) begin
            model_reset();
            e_state = 0;
            n_mc_left = 0; n_fl_left = 0; n_ack = 0;
        end else if (br) begin
            e_iff = 1; e_idf = 1;
            n_fl_left = FC - 1; n_mc_left = 0; n_ack = 0;
        end else if (fl_left > 0) begin
            e_iff = 1; e_idf = 1;
            n_fl_left = fl_left - 1; n_ack = 0;
        end else if (mc_left > 0) begin
            e_pc = 0; e_ifid = 0; e_idex = 0;
            n_mc_left = mc_left - 1;
            n_ack = (n_mc_left == 0);
        end else begin
            n_ack = 0;
            if (lu) begin
                e_pc = 0; e_ifid = 0; e_idf = 1;
            end else if (mc && !ack) begin
                e_pc = 0; e_ifid = 0; e_idex = 0;
                n_mc_left = MCL - 1;
                n_ack = (MCL == 1);
            end
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            if (!e_pc && stalls < 65535) stalls++;
            mc_left = n_mc_left; fl_left = n_fl_left; ack = n_ack;
        end
    endtask

    // Inputs are set by the caller just after a rising edge; outputs are
    // sampled mid-cycle and the model advances on the next rising edge.
    task automatic step(input string tag);
        #3;
        model_eval();
        chk({tag, "/pc_write"},     32'(pc_write),     32'(e_pc));
        chk({tag, "/if_id_write"},  32'(if_id_write),  32'(e_ifid));
        chk({tag, "/id_ex_enable"}, 32'(id_ex_enable), 32'(e_idex));
        chk({tag, "/if_id_flush"},  32'(if_id_flush),  32'(e_iff));
        chk({tag, "/id_ex_flush"},  32'(id_ex_flush),  32'(e_idf));
        chk({tag, "/state"},        32'(state),        32'(e_state));
        chk({tag, "/stall_count"},  32'(stall_count),  32'(stalls));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        rs = 0; rt = 0; wa = 0; mr = 0; br = 0; mc = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        // Reset state with hazard-provoking inputs present.
        mr = 1; wa = 5'd3; rs = 5'd3; mc = 1; br = 0;
        #2;
        chk("reset/pc_write",     32'(pc_write),     32'd1);
        chk("reset/id_ex_enable", 32'(id_ex_enable), 32'd1);
        chk("reset/id_ex_flush",  32'(id_ex_flush),  32'd0);
        chk("reset/state",        32'(state),        32'd0);
        chk("reset/stall_count",  32'(stall_count),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();

        // Load to $0 never stalls.
        mr = 1; wa = 0; rs = 0; step("lu_zero");
        clear_inputs(); step("lu_zero_after");
        chk("lu_zero/stall_count", 32'(stall_count), 32'd0);

        // Load-use on rs: one bubble cycle.
        mr = 1; wa = 5'd5; rs = 5'd5; rt = 5'd9; step("lu_rs");
        clear_inputs(); step("lu_rs_after");
        chk("lu_rs/stall_count", 32'(stall_count), 32'd1);

        // Load-use on rt.
        mr = 1; wa = 5'd7; rs = 5'd1; rt = 5'd7; step("lu_rt");
        clear_inputs(); step("lu_rt_after");

        // Multicycle held: 4 held cycles then ack cycle.
        mc = 1;
        for (int i = 0; i < 5; i++) step("mc_hold");
        chk("mc/state_after", 32'(state), 32'd0);
        mc = 0; step("mc_release");
        chk("mc/stall_count", 32'(stall_count), 32'd6);

        // Single taken branch: two flush cycles.
        br = 1; step("br_take");
        br = 0; step("br_flush");
        chk("br/state_back", 32'(state), 32'd0);
        step("br_after");

        // Branch and load-use together: branch wins, nothing stalled.
        br = 1; mr = 1; wa = 5'd5; rs = 5'd5; step("br_lu");
        clear_inputs(); step("br_lu_flush");
        chk("br_lu/stall_count", 32'(stall_count), 32'd6);

        // Branch during MC_WAIT aborts the hold.
        mc = 1; step("mc_abort0"); step("mc_abort1");
        br = 1; step("mc_abort_br");
        br = 0; mc = 0; step("mc_abort_flush"); step("mc_abort_run");

        // Async reset mid-MC_WAIT at cnt=1, then re-detection.
        mc = 1; step("rst_mc0"); step("rst_mc1");
        #3 rst = 1'b1;
        #1;
        chk("rst_async/state",       32'(state),        32'd0);
        chk("rst_async/stall_count", 32'(stall_count),  32'd0);
        chk("rst_async/pc_write",    32'(pc_write),     32'd1);
        chk("rst_async/id_ex_en",    32'(id_ex_enable), 32'd1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step("rst_redetect");
        chk("rst_redetect/state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) step("rst_redetect_run");
        mc = 0; step("rst_redetect_done");

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            wa  = 5'($urandom_range(0, 3));
            mr  = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 9) == 0);
            mc  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 49) == 0);
            step("random");
        end
        rst = 1'b0;
        clear_inputs();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MC_LATENCY, default 4, range 1..15: cycles the pipeline front end is held for a multicycle ALU op in ID.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7: consecutive cycles of flush after a taken branch.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_id_rs  in  5  rs field of the instruction in ID.
REQ-006 i_id_rt  in  5  rt field of the instruction in ID.
REQ-007 i_ex_mem_read  in  1  instruction in EX is a load.
REQ-008 i_ex_write_address  in  5  destination register of the instruction in EX.
REQ-009 i_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 i_id_multicycle  in  1  instruction in ID is a multicycle ALU op.
REQ-011 o_pc_write  out  1  PC update enable.
REQ-012 o_if_id_write  out  1  IF/ID buffer load enable.
REQ-013 o_id_ex_enable  out  1  ID/EX buffer load enable.
REQ-014 o_if_id_flush  out  1  IF/ID buffer loads a NOP.
REQ-015 o_id_ex_flush  out  1  ID/EX buffer loads a bubble (all zero).
REQ-016 o_state  out  2  current state: 0 RUN, 1 MC_WAIT, 2 FLUSH.
REQ-017 o_stall_count  out  16  saturating count of cycles with o_pc_write=0.

Function
REQ-018 States SHALL be RUN, MC_WAIT, FLUSH; a down-counter cnt (4 bits) and a one-bit mc_ack flag SHALL be held in registers.
REQ-019 Outputs SHALL be combinational from state, cnt, mc_ack and current inputs; defaults: pc_write=1, if_id_write=1, id_ex_enable=1, both flushes=0.
REQ-020 Load-use hazard SHALL be: i_ex_mem_read=1 and i_ex_write_address!=0 and (i_ex_write_address==i_id_rs or ==i_id_rt).
REQ-021 Priority each cycle SHALL be: branch taken > load-use > multicycle.
REQ-022 RUN + i_branch_taken: both flushes=1 this cycle; if FLUSH_CYCLES>1 next state FLUSH with cnt=FLUSH_CYCLES-2, else stay RUN.
REQ-023 RUN + load-use: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly this cycle; stay RUN (1-cycle bubble, no state).
REQ-024 RUN + i_id_multicycle + mc_ack=0: pc_write=0, if_id_write=0, id_ex_enable=0; if MC_LATENCY>1 next MC_WAIT with cnt=MC_LATENCY-2, else set mc_ack and stay RUN.
REQ-025 MC_WAIT: same hold outputs as REQ-024; cnt decrements; at cnt=0 next RUN and mc_ack set.
REQ-026 mc_ack=1 SHALL suppress multicycle detection for one RUN cycle, then clear; total hold for a multicycle op is exactly MC_LATENCY cycles.
REQ-027 FLUSH: both flushes=1, pc_write=1; cnt decrements; at cnt=0 next RUN.
REQ-028 i_branch_taken in MC_WAIT or FLUSH SHALL abort/restart: flushes=1 this cycle, counter reloaded per REQ-022, mc_ack cleared.
REQ-029 o_stall_count SHALL increment on each rising edge where o_pc_write=0 and SHALL hold at 16'hFFFF.

Reset
REQ-030 rst=1 SHALL immediately force state RUN, cnt=0, mc_ack=0, o_stall_count=0, independent of clk.
REQ-031 While rst=1 outputs SHALL be pc_write=1, if_id_write=1, id_ex_enable=1, flushes=0, regardless of inputs; reset mid-MC_WAIT or mid-FLUSH discards the sequence.

Structure
REQ-032 Shared package pipeline_pkg SHALL hold the state encoding, REG_ZERO=5'd0 and default MC_LATENCY/FLUSH_CYCLES values.
REQ-033 Load-use comparison SHALL be a combinational sub-module hazard_detect (inputs REQ-005..008, output lu_hazard).

Verification
REQ-034 EX load to $5, ID rs=$5 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1.
REQ-035 EX load to $0, ID rs=$0 -> no stall; all defaults.
REQ-036 i_id_multicycle held, MC_LATENCY=4 -> id_ex_enable=0 for exactly 4 cycles, o_state 0,1,1,1,0, stall_count=4.
REQ-037 i_branch_taken one cycle, FLUSH_CYCLES=2 -> both flushes=1 for 2 cycles, o_state 0 then 2 then 0.
REQ-038 Branch and load-use in same cycle -> flushes=1, pc_write=1, no stall counted.
REQ-039 rst pulsed mid-MC_WAIT (cnt=1) -> o_state=0, stall_count=0 asynchronously; pending multicycle re-detected after release.
